// File: rtl/kt_pkg.sv
// Definitions shared by the Knight's Tour host link: FSM states, response codes
// and the UART bit timing used by both ends of the serial link.
package kt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TX_HIGH,
    TX_LOW,
    WAIT_RESP
  } rc_state_t;

  localparam logic [7:0] ACK_RESP    = 8'hA5;
  localparam int         CLK_FREQ_HZ = 50_000_000;
  localparam int         BAUD_RATE   = 115_200;
  localparam int         BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART transceiver. tx_done is sticky until the next trmt; rx_rdy is sticky
// until clr_rx_rdy or the start of the next incoming frame.
module remote_comm_uart
  import kt_pkg::*;
#(
  parameter int BAUD_CLKS = BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam int                CNT_W     = $clog2(BAUD_CLKS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CLKS - 1);
  // Sync flops add two cycles, so start the first sample a little before mid-bit.
  localparam logic [CNT_W-1:0] RX_HALF   = CNT_W'(BAUD_CLKS / 2 - 2);

  logic [8:0]       r_tx_shift;
  logic [CNT_W-1:0] r_tx_baud;
  logic [3:0]       r_tx_bits;
  logic             r_tx_busy;
  logic             r_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '1;
      r_tx_baud  <= '0;
      r_tx_bits  <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else if (trmt) begin
      r_tx_shift <= {tx_data, 1'b0};
      r_tx_baud  <= '0;
      r_tx_bits  <= '0;
      r_tx_busy  <= 1'b1;
      r_tx_done  <= 1'b0;
    end else if (r_tx_busy) begin
      if (r_tx_baud == BAUD_LAST) begin
        r_tx_baud  <= '0;
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_bits  <= r_tx_bits + 4'd1;
        if (r_tx_bits == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_tx_done <= 1'b1;
        end
      end else begin
        r_tx_baud <= r_tx_baud + CNT_W'(1);
      end
    end
  end

  assign TX      = r_tx_shift[0];
  assign tx_done = r_tx_done;

  logic             r_rx_sync1;
  logic             r_rx_sync2;
  logic             r_rx_busy;
  logic [CNT_W-1:0] r_rx_baud;
  logic [3:0]       r_rx_bits;
  logic [7:0]       r_rx_shift;
  logic             r_rx_rdy;

  // Sample index 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_baud  <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_rx_rdy   <= 1'b0;
    end else begin
      r_rx_sync1 <= RX;
      r_rx_sync2 <= r_rx_sync1;
      if (clr_rx_rdy) r_rx_rdy <= 1'b0;
      if (!r_rx_busy) begin
        if (!r_rx_sync2) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= RX_HALF;
          r_rx_bits <= '0;
          r_rx_rdy  <= 1'b0;
        end
      end else if (r_rx_baud == '0) begin
        r_rx_baud <= BAUD_LAST;
        r_rx_bits <= r_rx_bits + 4'd1;
        if (r_rx_bits == 4'd9) begin
          r_rx_busy <= 1'b0;
          r_rx_rdy  <= 1'b1;
        end else if (r_rx_bits != 4'd0) begin
          r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
        end
      end else begin
        r_rx_baud <= r_rx_baud - CNT_W'(1);
      end
    end
  end

  assign rx_data = r_rx_shift;
  assign rx_rdy  = r_rx_rdy;

endmodule

// File: rtl/remote_comm.sv
// Host-side command sender: ships a 16-bit command as two UART bytes (high first),
// then waits for a one-byte response under a watchdog.
module remote_comm
  import kt_pkg::*;
#(
  parameter int               TMO_W          = 24,
  parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = TMO_W'(5_000_000),
  parameter int               BAUD_CLKS      = BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        timeout,
  output logic        TX,
  input  logic        RX
);

  rc_state_t        r_state, w_state_next;
  logic [15:0]      r_cmd;
  logic             r_lo_sel;
  logic             r_trmt;
  logic             r_tx_done_q;
  logic [7:0]       r_resp;
  logic             r_cmd_snt, r_resp_rdy, r_timeout;
  logic [TMO_W-1:0] r_cnt;

  logic       w_tx_done, w_rx_rdy, w_clr_rx_rdy, w_done_rise, w_terminal;
  logic [7:0] w_rx_data, w_tx_data;
  logic       w_accept, w_load_lo, w_sent, w_got_resp, w_expire;

  // Only a fresh rise counts: tx_done stays high from the previous byte until trmt.
  assign w_done_rise = w_tx_done & ~r_tx_done_q;
  assign w_terminal  = (r_cnt == TIMEOUT_CYCLES - TMO_W'(1));
  assign w_tx_data   = r_lo_sel ? r_cmd[7:0] : r_cmd[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (snd_cmd) w_state_next = TX_HIGH;
      TX_HIGH:   if (w_done_rise) w_state_next = TX_LOW;
      TX_LOW:    if (w_done_rise) w_state_next = WAIT_RESP;
      WAIT_RESP: if (w_rx_rdy || w_terminal) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept     = 1'b0;
    w_load_lo    = 1'b0;
    w_sent       = 1'b0;
    w_got_resp   = 1'b0;
    w_expire     = 1'b0;
    w_clr_rx_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept     = snd_cmd;
        w_clr_rx_rdy = w_rx_rdy;
      end
      TX_HIGH: w_load_lo = w_done_rise;
      TX_LOW:  w_sent    = w_done_rise;
      WAIT_RESP: begin
        w_got_resp   = w_rx_rdy;
        w_clr_rx_rdy = w_rx_rdy;
        w_expire     = w_terminal & ~w_rx_rdy;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= '0;
      r_lo_sel    <= 1'b0;
      r_trmt      <= 1'b0;
      r_tx_done_q <= 1'b0;
      r_resp      <= '0;
      r_cmd_snt   <= 1'b0;
      r_resp_rdy  <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_tx_done_q <= w_tx_done;
      r_trmt      <= w_accept | w_load_lo;
      if (w_accept) begin
        r_cmd      <= cmd;
        r_lo_sel   <= 1'b0;
        r_cmd_snt  <= 1'b0;
        r_resp_rdy <= 1'b0;
        r_timeout  <= 1'b0;
      end
      if (w_load_lo) r_lo_sel <= 1'b1;
      if (w_sent) begin
        r_cmd_snt <= 1'b1;
        r_cnt     <= '0;
      end else if (r_state == WAIT_RESP) begin
        r_cnt <= r_cnt + TMO_W'(1);
      end
      if (w_got_resp) begin
        r_resp     <= w_rx_data;
        r_resp_rdy <= 1'b1;
      end
      if (w_expire) r_timeout <= 1'b1;
    end
  end

  assign busy     = (r_state != IDLE);
  assign cmd_snt  = r_cmd_snt;
  assign resp     = r_resp;
  assign resp_rdy = r_resp_rdy;
  assign timeout  = r_timeout;

  remote_comm_uart #(
    .BAUD_CLKS(BAUD_CLKS)
  ) iUART (
    .clk       (clk),
    .rst_n     (rst_n),
    .trmt      (r_trmt),
    .tx_data   (w_tx_data),
    .tx_done   (w_tx_done),
    .TX        (TX),
    .RX        (RX),
    .clr_rx_rdy(w_clr_rx_rdy),
    .rx_data   (w_rx_data),
    .rx_rdy    (w_rx_rdy)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Bench for remote_comm: decodes the serial command stream, plays the responder
// on RX and checks flags/timing against a small expected-state model.
module tb_remote_comm;
  import kt_pkg::*;

  localparam int B = 16;
  localparam int T = 400;
  // Cycles from driving a response start bit to the edge where it is captured:
  // two sync flops, start detect, half-bit wait, nine more bit periods.
  localparam int RX_LAT = (B / 2 - 2) + 5 + 9 * B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        busy, cmd_snt, resp_rdy, timeout, TX;
  logic [7:0]  resp;
  logic        RX;

  int          n_tests;
  int          n_fail;
  logic [7:0]  exp_resp;

  remote_comm #(
    .TMO_W         (24),
    .TIMEOUT_CYCLES(24'd400),
    .BAUD_CLKS     (B)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd),
    .snd_cmd (snd_cmd),
    .busy    (busy),
    .cmd_snt (cmd_snt),
    .resp    (resp),
    .resp_rdy(resp_rdy),
    .timeout (timeout),
    .TX      (TX),
    .RX      (RX)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ok);
    int   n = 0;
    logic st, sp;
    b = '0;
    ok = 1'b0;
    while (TX !== 1'b0 && n < 4 * B) begin
      @(negedge clk);
      n++;
    end
    if (TX !== 1'b0) return;
    repeat (B / 2) @(negedge clk);
    st = TX;
    for (int i = 0; i < 8; i++) begin
      repeat (B) @(negedge clk);
      b[i] = TX;
    end
    repeat (B) @(negedge clk);
    sp = TX;
    ok = (st === 1'b0) && (sp === 1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
    repeat (B) @(negedge clk);
  endtask

  task automatic start_cmd(input logic [15:0] c);
    cmd     = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    cmd     = 16'($urandom);
    chk("busy_on_accept", busy, 1);
    chk("cmd_snt_cleared", cmd_snt, 0);
    chk("resp_rdy_cleared", resp_rdy, 0);
    chk("timeout_cleared", timeout, 0);
    chk("tx_idle_in_trmt_cycle", TX, 1);
    @(negedge clk);
    chk("tx_start_latency", TX, 0);
  endtask

  task automatic send_cmd_bytes(input logic [15:0] c, input bit repulse);
    logic [7:0] b;
    bit         ok;
    int         n;
    start_cmd(c);
    if (repulse) begin
      cmd     = 16'hFFFF;
      snd_cmd = 1'b1;
      @(negedge clk);
      snd_cmd = 1'b0;
    end
    get_byte(b, ok);
    chk("hi_frame", ok, 1);
    chk("hi_byte", b, c[15:8]);
    chk("busy_after_hi", busy, 1);
    get_byte(b, ok);
    chk("lo_frame", ok, 1);
    chk("lo_byte", b, c[7:0]);
    n = 0;
    while (cmd_snt !== 1'b1 && n < 4 * B) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_snt_set", cmd_snt, 1);
    chk("busy_in_wait", busy, 1);
  endtask

  task automatic respond(input logic [7:0] r, input int delay);
    repeat (delay) @(negedge clk);
    send_rx(r);
    exp_resp = r;
    chk("resp", resp, exp_resp);
    chk("resp_rdy", resp_rdy, 1);
    chk("busy_done", busy, 0);
    chk("timeout_quiet", timeout, 0);
    chk("cmd_snt_sticky", cmd_snt, 1);
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    int         n;

    n_tests  = 0;
    n_fail   = 0;
    exp_resp = 8'h00;
    rst_n    = 1'b0;
    snd_cmd  = 1'b0;
    cmd      = 16'h0000;
    RX       = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_snt", cmd_snt, 0);
    chk("rst_resp", resp, 0);
    chk("rst_resp_rdy", resp_rdy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tx", TX, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray byte while idle must be dropped.
    send_rx(8'h5A);
    repeat (4) @(negedge clk);
    chk("stray_resp_rdy", resp_rdy, 0);
    chk("stray_resp", resp, exp_resp);
    chk("stray_busy", busy, 0);

    // First command with a re-pulse during TX_HIGH and another in WAIT_RESP.
    send_cmd_bytes(16'h2345, 1'b1);
    cmd     = 16'hFFFF;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    chk("busy_snd_ignored_cmd_snt", cmd_snt, 1);
    chk("busy_snd_ignored_busy", busy, 1);
    respond(ACK_RESP, 50);

    for (int k = 0; k < 4; k++) begin
      send_cmd_bytes(16'($urandom), 1'b0);
      respond(8'($urandom), int'($urandom_range(0, 200)));
    end

    // No responder: timeout exactly T cycles after entering WAIT_RESP.
    send_cmd_bytes(16'h4021, 1'b0);
    n = 0;
    while (timeout !== 1'b1 && n < 2 * T) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, T);
    chk("timeout_busy", busy, 0);
    chk("timeout_resp_kept", resp, exp_resp);
    chk("timeout_resp_rdy", resp_rdy, 0);

    // Response captured on the terminal-count cycle wins.
    send_cmd_bytes(16'($urandom), 1'b0);
    repeat (T - RX_LAT) @(negedge clk);
    send_rx(8'h3C);
    exp_resp = 8'h3C;
    chk("race_win_resp", resp, exp_resp);
    chk("race_win_resp_rdy", resp_rdy, 1);
    chk("race_win_timeout", timeout, 0);
    chk("race_win_busy", busy, 0);

    // One cycle later the watchdog wins and the late byte is discarded.
    send_cmd_bytes(16'($urandom), 1'b0);
    repeat (T - RX_LAT + 1) @(negedge clk);
    send_rx(8'hC3);
    repeat (4) @(negedge clk);
    chk("race_lose_timeout", timeout, 1);
    chk("race_lose_resp_rdy", resp_rdy, 0);
    chk("race_lose_resp", resp, exp_resp);
    chk("race_lose_busy", busy, 0);

    // Reset in the middle of the low byte.
    start_cmd(16'hBEEF);
    get_byte(b, ok);
    chk("pre_reset_hi", b, 8'hBE);
    n = 0;
    while (TX !== 1'b0 && n < 4 * B) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_lo_start", TX, 0);
    repeat (3 * B) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_resp = 8'h00;
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_snt", cmd_snt, 0);
    chk("midrst_resp", resp, exp_resp);
    chk("midrst_resp_rdy", resp_rdy, 0);
    chk("midrst_timeout", timeout, 0);
    chk("midrst_tx", TX, 1);
    rst_n = 1'b1;
    @(negedge clk);
    send_cmd_bytes(16'h1234, 1'b0);
    respond(ACK_RESP, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
